// File: rtl/rotate_left_seq_pkg.sv
// Shared widths, state encoding and helpers
// for the serial rotate-left unit.
package rotate_left_seq_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] rotl1(
    input logic [WIDTH-1:0] v
  );
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

endpackage

// File: rtl/rotate_left_seq_if.sv
// Start/done request bundle between a client
// and the serial rotate-left unit.
interface rotate_left_seq_if;
  import rotate_left_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] In;
  logic [CNT_W-1:0] Cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Out;

  modport master (
    output start, In, Cnt,
    input  busy, done, Out
  );

  modport slave (
    input  start, In, Cnt,
    output busy, done, Out
  );

endinterface

// File: rtl/rotate_left_seq_cnt.sv
// Loadable down-counter holding the remaining
// rotate amount; saturates at zero.
module rot_cnt_down #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // load wins over decrement; never wraps below 0
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_val;
    else if (i_dec && r_cnt != '0)
      r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rotate_left_seq.sv
// Serial rotate-left: one bit per clock under
// a start/done handshake, result held in sreg.
module rotate_left_seq
  import rotate_left_seq_pkg::*;
(
  input logic         clk,
  input logic         rst,
  rotate_left_seq_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_dec;
  logic             w_zero;
  logic [WIDTH-1:0] r_sreg;

  rot_cnt_down #(
    .W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_dec  (w_dec),
    .i_val  (bus.Cnt),
    .o_zero (w_zero)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // next state, load and rotate strobes
  always_comb begin
    w_next = ST_IDLE;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!w_zero) begin
          w_dec  = 1'b1;
          w_next = ST_BUSY;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = ST_BUSY;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // operand shift register; also the result
  always_ff @(posedge clk) begin
    if (rst)
      r_sreg <= '0;
    else if (w_load)
      r_sreg <= bus.In;
    else if (w_dec)
      r_sreg <= rotl1(r_sreg);
  end

  assign bus.busy = (r_state == ST_BUSY);
  assign bus.done = (r_state == ST_DONE);
  assign bus.Out  = r_sreg;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Scoreboard bench for rotate_left_seq:
// directed vectors plus a random run.
module tb_rotate_left_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rotate_left_seq_if bus ();

  rotate_left_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] sb[$];

  function automatic logic [15:0] rotr(
    input logic [15:0] x,
    input int          s
  );
    if (s == 0) return x;
    return (x >> s) | (x << (16 - s));
  endfunction

  task automatic chk(
    input string       nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // monitor: every done pulse pops one result
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && bus.done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got %h want none",
                 bus.Out);
      end else begin
        e = sb.pop_front();
        if (bus.Out !== e) begin
          bad++;
          $display("FAIL result: got %h want %h",
                   bus.Out, e);
        end
      end
    end
  end

  // call at a negedge while DUT is IDLE or DONE;
  // returns at the negedge of the DONE cycle
  task automatic run_op(
    input logic [15:0] a,
    input logic [3:0]  c,
    input bit          poke,
    input logic [15:0] exp
  );
    int nb;
    bit ok;
    sb.push_back(exp);
    bus.start = 1'b1;
    bus.In    = a;
    bus.Cnt   = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_accept", 16'(bus.busy), 16'd1);
    nb = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        bus.start = 1'b0;
        break;
      end
      if (bus.busy) nb++;
      if (poke && bus.busy) begin
        bus.start = nb[0];
        bus.In    = 16'hFFFF;
        bus.Cnt   = 4'd7;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout: got no done want done");
    end
    chk("busy_cycles", 16'(nb), 16'(c) + 16'd1);
  endtask

  initial begin
    logic [15:0] a;
    logic [3:0]  c;
    bus.start = 1'b0;
    bus.In    = '0;
    bus.Cnt   = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_out", bus.Out, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 4'd4, 1'b0, 16'h2341);
    @(negedge clk);
    run_op(16'h8001, 4'd1, 1'b0, 16'h0003);
    @(negedge clk);
    run_op(16'h8001, 4'd0, 1'b0, 16'h8001);
    @(negedge clk);
    run_op(16'h0001, 4'd15, 1'b1, 16'h8000);
    repeat (3) @(negedge clk);
    chk("idle_hold_out", bus.Out, 16'h8000);
    chk("idle_done", 16'(bus.done), 16'd0);

    run_op(16'h00F0, 4'd2, 1'b0, 16'h03C0);
    run_op(16'hABCD, 4'd8, 1'b0, 16'hCDAB);
    @(negedge clk);

    // reset mid-BUSY drops the operation
    bus.start = 1'b1;
    bus.In    = 16'h1234;
    bus.Cnt   = 4'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 16'(bus.busy), 16'd0);
    chk("midrst_done", 16'(bus.done), 16'd0);
    chk("midrst_out", bus.Out, 16'h0000);

    // rst and start on the same edge
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.In    = 16'hFFFF;
    bus.Cnt   = 4'd2;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rststart_busy", 16'(bus.busy), 16'd0);
    chk("rststart_out", bus.Out, 16'h0000);

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        @(negedge clk);
      run_op(a, c, bit'($urandom_range(0, 1)),
             rotr(a, (16 - int'(c)) % 16));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
